seq_shifter: RTL and testbench

Parametrised multi-cycle shift unit. It replaces the fixed 32-bit, single-position left-shift wiring in the ALU datapath with a start/done block. The block supports a configurable data width, a variable shift amount, a per-cycle step size, and logical-left, logical-right and arithmetic-right modes, plus an optional rotate mode. The processor control issues a shift, stalls on `busy`, and captures `result` on `done`.

---
 rtl/seq_shifter.sv | 80 ++++++++
 tb/tb_seq_shifter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// Multi-cycle shift unit with start/done handshake: SLL, SRL, SRA, plus ROL when
// SEQ_SHIFTER_ROTATE_EN is defined (otherwise mode 11 behaves as SLL).
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [SW-1:0] StepAmt = SW'(STEP);
`ifdef SEQ_SHIFTER_ROTATE_EN
  localparam logic [SW:0] WidthAmt = (SW+1)'(WIDTH);
`endif

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  work_q;
  logic [SW-1:0]     rem_q;
  logic [1:0]        mode_q;
  logic [SW-1:0]     k;
  logic [WIDTH-1:0]  shifted;

  always_comb k = (rem_q < StepAmt) ? rem_q : StepAmt;

  always_comb begin
    shifted = work_q;
    case (mode_q)
      2'b01:   shifted = work_q >> k;
      2'b10:   shifted = $signed(work_q) >>> k;
`ifdef SEQ_SHIFTER_ROTATE_EN
      // k is never zero while shifting, so the right-shift amount stays below WIDTH.
      2'b11:   shifted = (work_q << k) | (work_q >> (WidthAmt - {1'b0, k}));
`endif
      default: shifted = work_q << k;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      work_q  <= '0;
      rem_q   <= '0;
      mode_q  <= 2'b00;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            work_q  <= data_in;
            rem_q   <= shamt;
            mode_q  <= mode;
            state_q <= (shamt == '0) ? StDone : StShift;
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          work_q <= shifted;
          rem_q  <= rem_q - k;
          if (rem_q == k) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = (state_q == StShift);
  assign done   = (state_q == StDone);
  assign result = work_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one instance with STEP=1 and one with STEP=4.
module tb_seq_shifter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start1 = 1'b0, start4 = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  shamt = '0;
  logic [31:0] data_in = '0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  seq_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .mode(mode), .shamt(shamt),
    .data_in(data_in), .busy(busy1), .done(done1), .result(result1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .mode(mode), .shamt(shamt),
    .data_in(data_in), .busy(busy4), .done(done4), .result(result4)
  );

  // Drive one start cycle; returns at the negedge after the accepting edge.
  task automatic issue(input bit sel, input logic [1:0] m, input logic [4:0] s,
                       input logic [31:0] d);
    @(negedge clock);
    mode = m; shamt = s; data_in = d;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0; start4 = 1'b0;
  endtask

  // Count busy cycles until done is seen; stops at the negedge where done is high.
  task automatic wait_done(input bit sel, output int nbusy, output bit seen);
    nbusy = 0; seen = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if (sel ? done4 : done1) begin seen = 1'b1; break; end
      if (sel ? busy4 : busy1) nbusy++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    @(negedge clock);
    checks++;
    if ({busy1, done1, busy4, done4} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy1, done1, busy4, done4});
    end
    checks++;
    if (result1 !== 32'h0) begin
      errors++; $display("FAIL reset_result1: got %h want 00000000", result1);
    end
    checks++;
    if (result4 !== 32'h0) begin
      errors++; $display("FAIL reset_result4: got %h want 00000000", result4);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_sll;
    int n; bit seen;
    issue(1'b0, 2'b00, 5'd1, 32'h0000_0001);
    wait_done(1'b0, n, seen);
    checks++;
    if (!seen || n != 1) begin
      errors++; $display("FAIL sll_latency: got seen=%0d busy=%0d want seen=1 busy=1", seen, n);
    end
    checks++;
    if (result1 !== 32'h0000_0002 || busy1 !== 1'b0) begin
      errors++; $display("FAIL sll_result: got %h busy=%b want 00000002 busy=0", result1, busy1);
    end
    @(negedge clock);
    checks++;
    if (done1 !== 1'b0 || result1 !== 32'h0000_0002) begin
      errors++; $display("FAIL sll_hold: got done=%b res=%h want done=0 res=00000002",
                         done1, result1);
    end
  endtask

  task automatic test_sra;
    int n; bit seen;
    issue(1'b0, 2'b10, 5'd4, 32'h8000_0000);
    wait_done(1'b0, n, seen);
    checks++;
    if (!seen || n != 4 || busy1 !== 1'b0) begin
      errors++; $display("FAIL sra_timing: got seen=%0d busy_cycles=%0d want 1/4", seen, n);
    end
    checks++;
    if (result1 !== 32'hF800_0000) begin
      errors++; $display("FAIL sra_result: got %h want f8000000", result1);
    end
    @(negedge clock);
    checks++;
    if (done1 !== 1'b0) begin
      errors++; $display("FAIL sra_single_done: got done=%b want 0", done1);
    end
  endtask

  task automatic test_step4;
    int n; bit seen;
    issue(1'b1, 2'b01, 5'd31, 32'hFFFF_FFFF);
    wait_done(1'b1, n, seen);
    checks++;
    if (!seen || n != 8) begin
      errors++; $display("FAIL srl4_cycles: got seen=%0d busy=%0d want 1/8", seen, n);
    end
    checks++;
    if (result4 !== 32'h0000_0001) begin
      errors++; $display("FAIL srl4_result: got %h want 00000001", result4);
    end
    issue(1'b1, 2'b00, 5'd0, 32'hA5A5_1234);
    checks++;
    if (done4 !== 1'b1 || busy4 !== 1'b0 || result4 !== 32'hA5A5_1234) begin
      errors++; $display("FAIL zero_shamt: got done=%b busy=%b res=%h want 1 0 a5a51234",
                         done4, busy4, result4);
    end
    issue(1'b1, 2'b10, 5'd6, 32'h8000_0000);
    wait_done(1'b1, n, seen);
    checks++;
    if (!seen || n != 2 || result4 !== 32'hFE00_0000) begin
      errors++; $display("FAIL sra4_partial: got busy=%0d res=%h want 2 fe000000", n, result4);
    end
    issue(1'b1, 2'b00, 5'd5, 32'h0000_0001);
    wait_done(1'b1, n, seen);
    checks++;
    if (!seen || n != 2 || result4 !== 32'h0000_0020) begin
      errors++; $display("FAIL sll4_partial: got busy=%0d res=%h want 2 00000020", n, result4);
    end
  endtask

  task automatic test_ignore_start;
    int n; bit seen;
    issue(1'b0, 2'b00, 5'd8, 32'h0000_0001);
    mode = 2'b01; shamt = 5'd1; data_in = 32'h0000_FFFF; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    wait_done(1'b0, n, seen);
    checks++;
    if (!seen || n != 7 || result1 !== 32'h0000_0100) begin
      errors++; $display("FAIL ignore_start: got busy=%0d res=%h want 7 00000100", n, result1);
    end
    @(negedge clock);
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL not_queued: got busy=%b done=%b want 0 0", busy1, done1);
    end
  endtask

  task automatic test_back_to_back;
    int n; bit seen;
    issue(1'b0, 2'b00, 5'd2, 32'h0000_0003);
    wait_done(1'b0, n, seen);
    checks++;
    if (!seen || result1 !== 32'h0000_000C) begin
      errors++; $display("FAIL b2b_first: got seen=%0d res=%h want 1 0000000c", seen, result1);
    end
    mode = 2'b01; shamt = 5'd1; data_in = 32'h0000_0010; start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++; $display("FAIL b2b_no_gap: got busy=%b done=%b want 1 0", busy1, done1);
    end
    @(negedge clock);
    checks++;
    if (done1 !== 1'b1 || result1 !== 32'h0000_0008) begin
      errors++; $display("FAIL b2b_second: got done=%b res=%h want 1 00000008", done1, result1);
    end
  endtask

  task automatic test_reset_mid;
    int n; int dones; bit seen;
    issue(1'b0, 2'b00, 5'd10, 32'h0000_000F);
    @(negedge clock);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || result1 !== 32'h0) begin
      errors++; $display("FAIL reset_mid: got busy=%b done=%b res=%h want 0 0 00000000",
                         busy1, done1, result1);
    end
    @(negedge clock);
    reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (done1) dones++;
    end
    checks++;
    if (dones != 0 || result1 !== 32'h0) begin
      errors++; $display("FAIL reset_no_done: got dones=%0d res=%h want 0 00000000",
                         dones, result1);
    end
    issue(1'b0, 2'b00, 5'd3, 32'h0000_0001);
    wait_done(1'b0, n, seen);
    checks++;
    if (!seen || n != 3 || result1 !== 32'h0000_0008) begin
      errors++; $display("FAIL reset_recover: got busy=%0d res=%h want 3 00000008", n, result1);
    end
  endtask

  task automatic test_rol;
    int n; bit seen;
    logic [31:0] exp;
`ifdef SEQ_SHIFTER_ROTATE_EN
    exp = 32'h3456_7812;
`else
    exp = 32'h3456_7800;
`endif
    issue(1'b0, 2'b11, 5'd8, 32'h1234_5678);
    wait_done(1'b0, n, seen);
    checks++;
    if (!seen || n != 8 || result1 !== exp) begin
      errors++; $display("FAIL rol: got busy=%0d res=%h want 8 %h", n, result1, exp);
    end
  endtask

  initial begin
    test_reset();
    test_sll();
    test_sra();
    test_step4();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_rol();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
